hilo_md_unit: RTL and testbench
===============================

# hilo_md_unit

Multiply/divide unit owning the HI and LO registers, sitting in the E stage of the five-stage MIPS pipeline.
- Issue side: the decoder issues HILO_Op and a one-cycle start; this block executes MULT/MULTU/DIV/DIVU over a fixed number of cycles.
- Status side: it reports HILO_busy back to the stall logic, executes MTHI/MTLO writes and supplies MFHI/MFLO read data.
- Flush side: a pipeline flush input (exception/interrupt) suppresses issue of the instruction currently in E.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy duration of DIV/DIVU (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle issue pulse for MULT/MULTU/DIV/DIVU in E
- HILO_Op  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, others = none
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- req  in  1  flush: instruction in E is cancelled this cycle
- HILO_busy  out  1  operation in progress
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- HILO_rdata  out  32  MFHI → HI, MFLO → LO, else 0 (combinational)

## Operation
State machine:
- States: IDLE, RUN.
- Internal registers: 4-bit cnt, 32-bit hi_pend and lo_pend.
- IDLE→RUN: edge with start=1, req=0, HILO_Op∈{1..4}.
  - On that edge: compute result into hi_pend/lo_pend.
  - Load cnt with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Set busy=1.
- RUN: each edge decrements cnt.
  - On the edge where cnt==1: HI←hi_pend, LO←lo_pend (unless divide-by-zero), busy←0, go to IDLE.

Arithmetic (64-bit product, 32-bit quotient/remainder):
- MULT: signed product; {HI,LO}=A*B.
- MULTU: same as MULT, unsigned.
- DIV: LO=quotient truncated toward zero, HI=remainder with the sign of A.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned.
- B==0 for DIV/DIVU: full DIV_CYCLES busy period; HI and LO unchanged at completion.

MTHI/MTLO:
- Write HI←A / LO←A on the edge where HILO_Op is 5/6, req=0 and busy=0. start is not required.

Issue filtering:
- start is ignored while busy=1 or req=1.
- start with HILO_Op∉{1..4} is ignored.
- MTHI/MTLO with req=1 or busy=1 are ignored.

Flush:
- req does not abort an operation already in RUN; it completes and commits.

Reset:
- Any time, including mid-RUN: HI=0, LO=0, busy=0, cnt=0, state IDLE, hi_pend=lo_pend=0.
- HILO_rdata follows HILO_Op (0 when op none).

## Timing
- start sampled at edge E0:
  - busy=1 in the cycles after E0 through edge E0+N, where N is MULT_CYCLES or DIV_CYCLES, i.e. exactly N cycles.
  - New HI/LO is visible in the same cycle busy returns to 0.
- Stall logic must stall MD/MF/MT instructions in D while busy=1 or start is asserted in E.
  - This block adds no extra bubble: back-to-back start on the first cycle busy=0 is accepted.
- HILO_rdata is a same-cycle combinational read of HI/LO.
  - An MFHI issued in the cycle busy falls reads the new value.
- MTHI and a completion never coincide (MT ignored while busy).

## Test plan
- Reset then idle: reset low mid-cycle → HI=LO=0, busy=0 immediately (async); HILO_Op=7 → rdata=0.
- MULT A=0xFFFFFFFE (−2), B=3 with start at E0 → busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA at busy fall; MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 → busy 10 cycles, HI/LO unchanged; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Flush and busy filtering:
  - start with req=1 → busy stays 0, HI/LO unchanged.
  - start during RUN → ignored; original result commits on schedule.
  - MTLO A=0x1234 while busy → ignored; after idle → LO=0x1234 next edge.
- Reset asserted at cycle 3 of a MULT → busy=0, HI=LO=0; after release, new MULT 6*7 → LO=42, HI=0 after 5 cycles.

Source files
------------

// File: rtl/hilo_md_unit.sv
// HI/LO multiply/divide unit for the E stage.
// MULT/MULTU/DIV/DIVU compute their result at issue into a pending pair.
// The pair is committed to HI/LO when the fixed busy window ends.
// MTHI/MTLO write directly while idle; MFHI/MFLO read combinationally.
module hilo_md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  HILO_Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        HILO_busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] HILO_rdata
);

    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

    typedef enum logic {StIdle, StRun} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi_pend;
    logic [31:0] lo_pend;
    logic        div_zero;

    logic        is_mul;
    logic        is_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] den_s;
    logic [31:0] den_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign is_mul = (HILO_Op == 4'd1) || (HILO_Op == 4'd2);
    assign is_div = (HILO_Op == 4'd3) || (HILO_Op == 4'd4);

    // Result datapath for the op presented at issue.
    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'd0, A} * {32'd0, B};
        abs_a  = A[31] ? (32'd0 - A) : A;
        abs_b  = B[31] ? (32'd0 - B) : B;
        // Divisor forced to 1 on B==0 so no X escapes; that result is never committed.
        den_s  = (B == 32'd0) ? 32'd1 : abs_b;
        den_u  = (B == 32'd0) ? 32'd1 : B;
        q_mag  = abs_a / den_s;
        r_mag  = abs_a % den_s;
        q_s    = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
        r_s    = A[31] ? (32'd0 - r_mag) : r_mag;
        q_u    = A / den_u;
        r_u    = A % den_u;
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (HILO_Op)
            4'd1: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            4'd2: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            4'd3: begin res_hi = r_s;           res_lo = q_s;          end
            4'd4: begin res_hi = r_u;           res_lo = q_u;          end
            default: ;
        endcase
    end

    // Issue/run FSM with registered busy and HI/LO state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            cnt       <= 4'd0;
            hi_pend   <= 32'd0;
            lo_pend   <= 32'd0;
            div_zero  <= 1'b0;
            HILO_busy <= 1'b0;
            HI        <= 32'd0;
            LO        <= 32'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (start && !req && (is_mul || is_div)) begin
                        hi_pend   <= res_hi;
                        lo_pend   <= res_lo;
                        div_zero  <= is_div && (B == 32'd0);
                        cnt       <= is_mul ? MultLoad : DivLoad;
                        HILO_busy <= 1'b1;
                        state     <= StRun;
                    end else if (!req && (HILO_Op == 4'd5)) begin
                        HI <= A;
                    end else if (!req && (HILO_Op == 4'd6)) begin
                        LO <= A;
                    end
                end
                StRun: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (!div_zero) begin
                            HI <= hi_pend;
                            LO <= lo_pend;
                        end
                        HILO_busy <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // MFHI/MFLO read port.
    always_comb begin
        HILO_rdata = 32'd0;
        case (HILO_Op)
            4'd7:    HILO_rdata = HI;
            4'd8:    HILO_rdata = LO;
            default: HILO_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Bench for hilo_md_unit: directed literal checks, then random traffic vs. a model.
module tb_hilo_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  hilo_op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        req = 1'b0;
    logic        hilo_busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    hilo_md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .HILO_Op(hilo_op), .A(a), .B(b), .req(req),
        .HILO_busy(hilo_busy), .HI(hi), .LO(lo), .HILO_rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: {div_by_zero, hi, lo} from plain SV arithmetic.
    function automatic logic [64:0] md_result(input logic [3:0] op, input logic [31:0] x,
                                              input logic [31:0] y);
        longint          p;
        longint unsigned pu;
        longint          q;
        longint          r;
        case (op)
            4'd1: begin p = longint'($signed(x)) * longint'($signed(y)); return {1'b0, p}; end
            4'd2: begin pu = {32'd0, x} * {32'd0, y}; return {1'b0, pu}; end
            4'd3: begin
                if (y == 32'd0) return {1'b1, 64'd0};
                q = longint'($signed(x)) / longint'($signed(y));
                r = longint'($signed(x)) % longint'($signed(y));
                return {1'b0, r[31:0], q[31:0]};
            end
            4'd4: begin
                if (y == 32'd0) return {1'b1, 64'd0};
                return {1'b0, x % y, x / y};
            end
            default: return 65'd0;
        endcase
    endfunction

    logic [64:0] cur_res;
    assign cur_res = md_result(hilo_op, a, b);

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_ph = 32'd0;
    logic [31:0] m_pl = 32'd0;
    logic        m_dz = 1'b0;
    int          m_left = 0;

    // Model: remaining busy cycles and a pending result pair.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi <= 0; m_lo <= 0; m_ph <= 0; m_pl <= 0; m_dz <= 0; m_left <= 0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && !m_dz) begin
                m_hi <= m_ph;
                m_lo <= m_pl;
            end
        end else if (start && !req && hilo_op >= 4'd1 && hilo_op <= 4'd4) begin
            m_dz   <= cur_res[64];
            m_ph   <= cur_res[63:32];
            m_pl   <= cur_res[31:0];
            m_left <= (hilo_op <= 4'd2) ? MC : DC;
        end else if (!req && hilo_op == 4'd5) begin
            m_hi <= a;
        end else if (!req && hilo_op == 4'd6) begin
            m_lo <= a;
        end
    end

    // Compare DUT against the model every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, hilo_busy}, {31'd0, m_left != 0});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("rdata", rdata, (hilo_op == 4'd7) ? m_hi : (hilo_op == 4'd8) ? m_lo : 32'd0);
        end
    end

    // Issue one op, optionally poke another request during the busy window, then check results.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input int exp_n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic i_start, input logic [3:0] i_op,
                          input logic [31:0] i_a);
        int cycles;
        @(posedge clk); #1;
        start = 1'b1; hilo_op = op; a = x; b = y; req = 1'b0;
        @(posedge clk); #1;
        start = i_start; hilo_op = i_op; a = i_a; b = 32'd3;
        cycles = 0;
        while (hilo_busy && cycles < 64) begin
            @(posedge clk); #1;
            start = 1'b0; hilo_op = 4'd0;
            cycles++;
        end
        chk({name, "_cycles"}, 32'(cycles), 32'(exp_n));
        chk({name, "_hi"}, hi, exp_hi);
        chk({name, "_lo"}, lo, exp_lo);
        chk({name, "_model_hi"}, m_hi, exp_hi);
        chk({name, "_model_lo"}, m_lo, exp_lo);
    endtask

    initial begin
        // Asynchronous reset mid-cycle.
        #3 reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, hilo_busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        hilo_op = 4'd7;
        #1 chk("rst_rdata", rdata, 32'd0);
        hilo_op = 4'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk_en = 1'b1;

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, 0);
        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, MC, 32'h0000_0002, 32'hFFFF_FFFA, 0, 0, 0);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0);
        run_op("divu0", 4'd4, 32'd7, 32'd0, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000, 0, 0, 0);

        // Start under flush is dropped.
        start = 1'b1; hilo_op = 4'd1; a = 32'd5; b = 32'd5; req = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hilo_op = 4'd0; req = 1'b0;
        chk("flush_busy", {31'd0, hilo_busy}, 32'd0);
        chk("flush_hi", hi, 32'd0);
        chk("flush_lo", lo, 32'h8000_0000);

        // Start while running is ignored; MTLO while running is ignored.
        run_op("mult_intr", 4'd1, 32'd6, 32'd7, MC, 32'd0, 32'd42, 1'b1, 4'd3, 32'd100);
        run_op("mult_mt", 4'd1, 32'd2, 32'd3, MC, 32'd0, 32'd6, 1'b0, 4'd6, 32'h1234);

        hilo_op = 4'd6; a = 32'h1234;
        @(posedge clk); #1;
        hilo_op = 4'd5; a = 32'hDEAD;
        chk("mtlo", lo, 32'h1234);
        @(posedge clk); #1;
        hilo_op = 4'd7;
        chk("mthi", hi, 32'hDEAD);
        #1 chk("mfhi", rdata, 32'hDEAD);
        hilo_op = 4'd0;

        // Reset during the third cycle of a MULT.
        start = 1'b1; hilo_op = 4'd1; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; hilo_op = 4'd0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, hilo_busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_op("mult_after", 4'd1, 32'd6, 32'd7, MC, 32'd0, 32'd42, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset   = ($urandom_range(0, 399) != 0);
            start   = ($urandom_range(0, 3) == 0);
            hilo_op = 4'($urandom_range(0, 9));
            req     = ($urandom_range(0, 7) == 0);
            a       = $urandom;
            b       = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
        end
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0; hilo_op = 4'd0; req = 1'b0;
        repeat (DC + 2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
